// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with Mealy and Moore match strobes,
// optional overlapping detection, synchronous clear and a saturating match counter.
`timescale 1ns/1ps

module seq_detector_param #(
  parameter int unsigned PAT_W   = 4,
  parameter              PATTERN = 4'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             dout_mealy,
  output logic             dout_moore,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] PAT = PAT_W'(PATTERN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  // Reject unsupported pattern lengths and mis-sized patterns at elaboration
  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $fatal(1, "seq_detector_param: PAT_W must be within 2..16");
  end
  if ($bits(PATTERN) != PAT_W) begin : g_bad_pattern
    $fatal(1, "seq_detector_param: PATTERN must be exactly PAT_W bits wide");
  end

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  window;
  logic [FILL_W-1:0] fill;
  logic              hit;

  // Candidate window and match term; fill guard masks stale or reset-zero history
  always_comb begin
    window = {hist[PAT_W-2:0], din};
    hit    = rstn & ~clear & din_valid & (fill >= FILL_ARM) & (window == PAT);
  end

  // Same-cycle match strobe
  always_comb begin
    dout_mealy = hit;
  end

  // Bit history and fill count; clear wins over an accepted bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (din_valid) begin
      hist <= window;
      if (hit && !OVERLAP) begin
        fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Registered match strobe, one cycle behind the Mealy strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_moore <= 1'b0;
    end else begin
      dout_moore <= hit;
    end
  end

  // Saturating match counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      match_cnt <= '0;
    end else if (clear) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param across several parameter sets.
`timescale 1ns/1ps

module tb_seq_detector_param;

  logic clk;
  logic rstn;
  logic din;
  logic din_valid;
  logic clear;

  logic       mealy_def, moore_def;
  logic [7:0] cnt_def;
  logic       mealy_nov, moore_nov;
  logic [7:0] cnt_nov;
  logic       mealy_c2, moore_c2;
  logic [1:0] cnt_c2;
  logic       mealy_z, moore_z;
  logic [7:0] cnt_z;

  int passed;
  int total;

  bit s1  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit e1d [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  bit e1n [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit p4  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  seq_detector_param u_def (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout_mealy(mealy_def), .dout_moore(moore_def), .match_cnt(cnt_def)
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout_mealy(mealy_nov), .dout_moore(moore_nov), .match_cnt(cnt_nov)
  );

  seq_detector_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout_mealy(mealy_c2), .dout_moore(moore_c2), .match_cnt(cnt_c2)
  );

  seq_detector_param #(.PATTERN(4'b0000)) u_z (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .clear(clear),
    .dout_mealy(mealy_z), .dout_moore(moore_z), .match_cnt(cnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs just after the rising edge, then settle at the falling edge
  task automatic apply(input logic d, input logic v, input logic c);
    @(posedge clk);
    #1;
    din = d;
    din_valid = v;
    clear = c;
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total = 0;
    rstn = 1'b0;
    din = 1'b0;
    din_valid = 1'b0;
    clear = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mealy", 32'(mealy_def), 32'd0);
    chk("rst_moore", 32'(moore_def), 32'd0);
    chk("rst_cnt", 32'(cnt_def), 32'd0);
    rstn = 1'b1;

    // Test 1/2a: overlapping vs non-overlapping on 1011011
    for (int i = 0; i < 7; i++) begin
      apply(s1[i], 1'b1, 1'b0);
      chk($sformatf("t1_mealy_def[%0d]", i), 32'(mealy_def), 32'(e1d[i]));
      chk($sformatf("t1_mealy_nov[%0d]", i), 32'(mealy_nov), 32'(e1n[i]));
      if (i > 0) chk($sformatf("t1_moore_def[%0d]", i), 32'(moore_def), 32'(e1d[i-1]));
    end
    apply(1'b0, 1'b0, 1'b0);
    chk("t1_moore_last", 32'(moore_def), 32'd1);
    chk("t1_cnt_def", 32'(cnt_def), 32'd2);
    chk("t2_cnt_nov", 32'(cnt_nov), 32'd1);
    chk("t2_moore_nov", 32'(moore_nov), 32'd0);

    // Test 2b: non-overlapping instance rearms after four fresh bits
    for (int i = 0; i < 4; i++) begin
      apply(p4[i], 1'b1, 1'b0);
      chk($sformatf("t2_mealy_nov[%0d]", i), 32'(mealy_nov), (i == 3) ? 32'd1 : 32'd0);
    end
    apply(1'b0, 1'b0, 1'b0);
    chk("t2_cnt_nov2", 32'(cnt_nov), 32'd2);

    // Test 3: valid gaps are transparent
    apply(1'b0, 1'b0, 1'b1);
    chk("t3_clear_mealy", 32'(mealy_def), 32'd0);
    apply(1'b1, 1'b1, 1'b0);
    chk("t3_cnt_cleared", 32'(cnt_def), 32'd0);
    chk("t3_mealy0", 32'(mealy_def), 32'd0);
    apply(1'b0, 1'b1, 1'b0);
    chk("t3_mealy1", 32'(mealy_def), 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0);
      chk($sformatf("t3_gap_mealy[%0d]", i), 32'(mealy_def), 32'd0);
      chk($sformatf("t3_gap_moore[%0d]", i), 32'(moore_def), 32'd0);
    end
    apply(1'b1, 1'b1, 1'b0);
    chk("t3_mealy2", 32'(mealy_def), 32'd0);
    apply(1'b1, 1'b1, 1'b0);
    chk("t3_mealy3", 32'(mealy_def), 32'd1);
    apply(1'b0, 1'b0, 1'b0);
    chk("t3_moore", 32'(moore_def), 32'd1);
    chk("t3_cnt", 32'(cnt_def), 32'd1);
    apply(1'b0, 1'b0, 1'b0);
    chk("t3_moore_width", 32'(moore_def), 32'd0);

    // Test 4: 2-bit counter saturates at 3 while Moore keeps pulsing
    apply(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 4; i++) apply(p4[i], 1'b1, 1'b0);
      chk($sformatf("t4_mealy_c2[%0d]", k), 32'(mealy_c2), 32'd1);
      apply(1'b0, 1'b0, 1'b0);
      chk($sformatf("t4_moore_c2[%0d]", k), 32'(moore_c2), 32'd1);
      chk($sformatf("t4_cnt_c2[%0d]", k), 32'(cnt_c2), (k < 3) ? 32'(k) : 32'd3);
    end

    // Test 5: clear discards history and its own bit
    apply(1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    chk("t5_clear_mealy", 32'(mealy_def), 32'd0);
    apply(1'b0, 1'b1, 1'b0);
    chk("t5_cnt_after_clear", 32'(cnt_def), 32'd0);
    chk("t5_m0", 32'(mealy_def), 32'd0);
    apply(1'b1, 1'b1, 1'b0);
    chk("t5_m1", 32'(mealy_def), 32'd0);
    apply(1'b1, 1'b1, 1'b0);
    chk("t5_m2", 32'(mealy_def), 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply(p4[i], 1'b1, 1'b0);
      chk($sformatf("t5_mealy[%0d]", i), 32'(mealy_def), (i == 3) ? 32'd1 : 32'd0);
    end
    apply(1'b0, 1'b0, 1'b1);
    chk("t5_moore_in_clear", 32'(moore_def), 32'd1);
    chk("t5_cnt", 32'(cnt_def), 32'd1);
    apply(1'b0, 1'b0, 1'b0);
    chk("t5_moore_after_clear", 32'(moore_def), 32'd0);
    chk("t5_cnt_after_clear2", 32'(cnt_def), 32'd0);

    // Test 6: all-zero pattern straight from reset, then async reset mid-pattern
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0);
      chk($sformatf("t6_mealy_z[%0d]", i), 32'(mealy_z), 32'd0);
    end
    apply(1'b0, 1'b1, 1'b0);
    chk("t6_mealy_z4", 32'(mealy_z), 32'd1);
    @(posedge clk);
    #1;
    din = 1'b0;
    din_valid = 1'b1;
    clear = 1'b0;
    #1;
    chk("t6_moore_pre_rst", 32'(moore_z), 32'd1);
    chk("t6_cnt_pre_rst", 32'(cnt_z), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_async_mealy", 32'(mealy_z), 32'd0);
    chk("t6_async_moore", 32'(moore_z), 32'd0);
    chk("t6_async_cnt", 32'(cnt_z), 32'd0);
    din_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 1'b0);
      chk($sformatf("t6_rel_mealy_z[%0d]", i), 32'(mealy_z), (i == 3) ? 32'd1 : 32'd0);
    end
    apply(1'b0, 1'b0, 1'b0);
    chk("t6_rel_cnt_z", 32'(cnt_z), 32'd1);
    chk("t6_rel_moore_z", 32'(moore_z), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector, successor to the fixed 1011 Mealy detector. It watches a qualified serial bit stream for a compile-time PATTERN of PAT_W bits. It provides a Mealy (same-cycle) match strobe, a Moore (registered) match strobe, overlapping or non-overlapping detection, a synchronous clear, and a saturating match counter. It sits between a serial data source and a control/status consumer in the lab datapath.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1011, target pattern; MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rstn  input  1  asynchronous active-low reset.
din  input  1  serial data bit; sampled only when din_valid=1.
din_valid  input  1  qualifies din for the current cycle.
clear  input  1  synchronous clear of history, fill count, Moore output and counter.
dout_mealy  output  1  combinational match strobe, high in the cycle of the completing bit.
dout_moore  output  1  registered match strobe, high the cycle after dout_mealy.
match_cnt  output  CNT_W  saturating count of matches since reset or clear.

Behaviour:
- State:
  - hist[PAT_W-1:0] holds the last valid bits; the newest bit is in the LSB.
  - fill counts accepted valid bits, range 0..PAT_W, saturating at PAT_W.
- Reset (rstn=0, asynchronous): hist=0, fill=0, dout_moore=0, match_cnt=0. dout_mealy is forced 0 while rstn=0. Reset takes effect immediately, including mid-pattern.
- Match term: hit = rstn & ~clear & din_valid & (fill >= PAT_W-1) & ({hist[PAT_W-2:0], din} == PATTERN).
  - The fill guard stops the reset-zero history from producing a false match (for example PATTERN=0000).
- dout_mealy = hit. It has zero latency and depends combinationally on din, din_valid and clear.
- Accepted bit (din_valid=1, clear=0), at the rising edge:
  - hist <= {hist[PAT_W-2:0], din}.
  - fill <= min(fill+1, PAT_W).
  - If hit and OVERLAP=0: fill <= 0 instead. hist is still shifted, but the fill guard masks it until PAT_W new bits arrive.
- din_valid=0: hist and fill hold and hit=0. Gaps of any length are transparent to detection.
- dout_moore <= hit every cycle. It is exactly one cycle wide per match and delayed one cycle from dout_mealy. Back-to-back hits give back-to-back highs.
- match_cnt <= match_cnt+1 on hit, saturating at 2^CNT_W-1. There is no wrap.
- Clear (clear=1, synchronous): at the next edge hist=0, fill=0, dout_moore=0, match_cnt=0.
  - clear has priority over din_valid; the bit presented with clear is discarded.
  - hit=0 in the clear cycle.
  - A dout_moore that is already high stays high for its cycle and drops at the clear edge.
- Elaboration checks:
  - PAT_W<2 or PAT_W>16 is a fatal error.
  - PATTERN must be PAT_W bits wide.

Test Plan:
1. Defaults, valid stream 1,0,1,1,0,1,1 -> dout_mealy high on bits 4 and 7; dout_moore high one cycle after each; match_cnt=2.
2. OVERLAP=0, same stream -> dout_mealy high on bit 4 only; match_cnt=1. Follow with 1,0,1,1 -> match on the 4th of these bits; match_cnt=2.
3. Valid bits 1,0, then 3 cycles of din_valid=0 with din=1, then valid 1,1 -> no strobe during the gap; dout_mealy high on the final valid bit; match_cnt=1.
4. CNT_W=2, five separated 1011 patterns -> match_cnt steps 1,2,3,3,3; dout_moore still pulses 5 times.
5. Valid 1,0,1, then clear=1 with din=1,din_valid=1, then 0,1,1 -> no match across the clear. Then 1,0,1,1 -> match; match_cnt=1.
6. PATTERN=4'b0000 straight out of reset with 3 zeros, then rstn pulsed low between edges mid-pattern -> no match on the first 3 zeros; all outputs 0 asynchronously during reset; the first match comes on the 4th zero after release.
